mod_ctl: RTL and testbench

Per-operation sequencer for the mod datapath (read/fill/copy/encode/decode engines sharing one src/dst FIFO pair).
- Accepts one operation descriptor at a time from the descriptor engine.
- Validates the opcode and drives the datapath control inputs: m_reset, m_enable, dc.
- Watches end-of-operation (m_endn) and FIFO handshake activity, with an inactivity timeout and abort.
- Returns one status record per operation, carrying beat counts.

---
 rtl/mod_ctl.sv | 161 ++++++++++++++++
 tb/tb_mod_ctl.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mod_ctl.sv
// mod_ctl: per-operation sequencer for the mod datapath.
// Validates a descriptor, sequences datapath reset/run, counts FIFO beats and returns status.
module mod_ctl #(
    parameter int             TAGW    = 4,
    parameter int             CNTW    = 16,
    parameter int             RST_CYC = 2,
    parameter int             TOW     = 20,
    parameter logic [TOW-1:0] TIMEOUT = 20'hFFFFF
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_n,
    input  logic            op_valid,
    output logic            op_ready,
    input  logic [23:0]     op_dc,
    input  logic [TAGW-1:0] op_tag,
    output logic            m_reset,
    output logic            m_enable,
    output logic [23:0]     dc,
    input  logic            m_endn,
    input  logic            m_src_getn,
    input  logic            m_dst_putn,
    input  logic            abort,
    output logic            st_valid,
    input  logic            st_ready,
    output logic [TAGW-1:0] st_tag,
    output logic [1:0]      st_code,
    output logic [CNTW-1:0] st_src_cnt,
    output logic [CNTW-1:0] st_dst_cnt,
    output logic            busy
);
    // state | meaning
    // IDLE  | waiting for a descriptor, datapath held in reset
    // RST   | datapath reset pulse ahead of the run
    // RUN   | datapath enabled, beats counted, watching end/abort/timeout
    // FLUSH | datapath reset after abort or timeout
    // STAT  | status record offered until taken
    typedef enum logic [2:0] {
        S_IDLE,
        S_RST,
        S_RUN,
        S_FLUSH,
        S_STAT
    } state_t;

    localparam int              RCW      = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [RCW-1:0]  RST_LOAD = RCW'(RST_CYC - 1);
    localparam logic [TOW-1:0]  TO_LOAD  = TIMEOUT - TOW'(1);
    localparam logic [CNTW-1:0] CNT_MAX  = '1;

    localparam logic [1:0] CODE_OK      = 2'b00;
    localparam logic [1:0] CODE_ABORT   = 2'b01;
    localparam logic [1:0] CODE_BADOP   = 2'b10;
    localparam logic [1:0] CODE_TIMEOUT = 2'b11;

    state_t          state, state_nxt;
    logic [RCW-1:0]  rst_cnt, rst_cnt_nxt;
    logic [TOW-1:0]  to_cnt, to_cnt_nxt;
    logic [CNTW-1:0] src_nxt, dst_nxt;
    logic [1:0]      code_nxt;
    logic [23:0]     dc_nxt;
    logic [TAGW-1:0] tag_nxt;
    logic            accept, active, op_good;

    assign accept  = op_valid & op_ready;
    assign active  = ~m_src_getn | ~m_dst_putn;
    assign op_good = $onehot(op_dc[6:2]);

    always_comb begin
        state_nxt   = state;
        rst_cnt_nxt = rst_cnt;
        to_cnt_nxt  = to_cnt;
        src_nxt     = st_src_cnt;
        dst_nxt     = st_dst_cnt;
        code_nxt    = st_code;
        dc_nxt      = dc;
        tag_nxt     = st_tag;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    dc_nxt      = op_dc;
                    tag_nxt     = op_tag;
                    src_nxt     = '0;
                    dst_nxt     = '0;
                    to_cnt_nxt  = TO_LOAD;
                    rst_cnt_nxt = RST_LOAD;
                    if (op_good) begin
                        state_nxt = S_RST;
                    end else begin
                        state_nxt = S_STAT;
                        code_nxt  = CODE_BADOP;
                    end
                end
            end
            S_RST: begin
                if (rst_cnt == '0) state_nxt = S_RUN;
                else               rst_cnt_nxt = rst_cnt - RCW'(1);
            end
            S_RUN: begin
                if (!m_src_getn && st_src_cnt != CNT_MAX) src_nxt = st_src_cnt + CNTW'(1);
                if (!m_dst_putn && st_dst_cnt != CNT_MAX) dst_nxt = st_dst_cnt + CNTW'(1);
                // idle timer counts down from TIMEOUT-1; any FIFO beat reloads it
                if (active)             to_cnt_nxt = TO_LOAD;
                else if (to_cnt != '0)  to_cnt_nxt = to_cnt - TOW'(1);
                if (!m_endn) begin
                    state_nxt = S_STAT;
                    code_nxt  = CODE_OK;
                end else if (abort) begin
                    state_nxt   = S_FLUSH;
                    code_nxt    = CODE_ABORT;
                    rst_cnt_nxt = RST_LOAD;
                end else if (TIMEOUT != '0 && !active && to_cnt == '0) begin
                    state_nxt   = S_FLUSH;
                    code_nxt    = CODE_TIMEOUT;
                    rst_cnt_nxt = RST_LOAD;
                end
            end
            S_FLUSH: begin
                if (rst_cnt == '0) state_nxt = S_STAT;
                else               rst_cnt_nxt = rst_cnt - RCW'(1);
            end
            S_STAT: begin
                if (st_ready) state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // outputs are registered from the next state so they line up with state
    always_ff @(posedge wb_clk_i) begin
        if (!wb_rst_n) begin
            state      <= S_IDLE;
            rst_cnt    <= '0;
            to_cnt     <= '0;
            m_reset    <= 1'b1;
            m_enable   <= 1'b0;
            dc         <= '0;
            op_ready   <= 1'b0;
            st_valid   <= 1'b0;
            st_tag     <= '0;
            st_code    <= '0;
            st_src_cnt <= '0;
            st_dst_cnt <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            rst_cnt    <= rst_cnt_nxt;
            to_cnt     <= to_cnt_nxt;
            m_reset    <= (state_nxt != S_RUN);
            m_enable   <= (state_nxt == S_RUN);
            dc         <= dc_nxt;
            op_ready   <= (state_nxt == S_IDLE);
            st_valid   <= (state_nxt == S_STAT);
            st_tag     <= tag_nxt;
            st_code    <= code_nxt;
            st_src_cnt <= src_nxt;
            st_dst_cnt <= dst_nxt;
            busy       <= (state_nxt != S_IDLE);
        end
    end

endmodule

// File: tb/tb_mod_ctl.sv
// tb_mod_ctl: directed and randomized operations against an operation-level reference model.
// Short timeout and narrow counters so timeout and saturation are reachable quickly.
module tb_mod_ctl;
    localparam int TAGW    = 4;
    localparam int CNTW    = 4;
    localparam int RST_CYC = 2;
    localparam int TOW     = 20;
    localparam int TMO     = 16;
    localparam int CMAX    = (1 << CNTW) - 1;

    logic            clk = 1'b0;
    logic            wb_rst_n;
    logic            op_valid, op_ready;
    logic [23:0]     op_dc;
    logic [TAGW-1:0] op_tag;
    logic            m_reset, m_enable;
    logic [23:0]     dc;
    logic            m_endn, m_src_getn, m_dst_putn, abort;
    logic            st_valid, st_ready;
    logic [TAGW-1:0] st_tag;
    logic [1:0]      st_code;
    logic [CNTW-1:0] st_src_cnt, st_dst_cnt;
    logic            busy;

    int n_chk = 0;
    int n_err = 0;

    // per-RUN-cycle stimulus for the current operation
    logic v_getn[64];
    logic v_putn[64];
    logic v_endn[64];
    logic v_abort[64];

    mod_ctl #(
        .TAGW(TAGW), .CNTW(CNTW), .RST_CYC(RST_CYC), .TOW(TOW), .TIMEOUT(20'd16)
    ) dut (
        .wb_clk_i(clk), .wb_rst_n(wb_rst_n),
        .op_valid(op_valid), .op_ready(op_ready), .op_dc(op_dc), .op_tag(op_tag),
        .m_reset(m_reset), .m_enable(m_enable), .dc(dc),
        .m_endn(m_endn), .m_src_getn(m_src_getn), .m_dst_putn(m_dst_putn), .abort(abort),
        .st_valid(st_valid), .st_ready(st_ready), .st_tag(st_tag), .st_code(st_code),
        .st_src_cnt(st_src_cnt), .st_dst_cnt(st_dst_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic clr_vec(input int n);
        for (int i = 0; i < 64; i++) begin
            v_getn[i] = 1'b1; v_putn[i] = 1'b1; v_endn[i] = 1'b1; v_abort[i] = 1'b0;
        end
        v_endn[n-1] = 1'b0;
    endtask

    // Operation-level model: walk the RUN cycles, applying end > abort > timeout.
    function automatic void model(input int n, output int code, output int src,
                                  output int dst, output int runs);
        int idle = 0;
        src = 0; dst = 0; code = 0; runs = n;
        for (int i = 0; i < n; i++) begin
            if (!v_getn[i] && src < CMAX) src++;
            if (!v_putn[i] && dst < CMAX) dst++;
            if (!v_endn[i]) begin code = 0; runs = i + 1; break; end
            if (v_abort[i]) begin code = 1; runs = i + 1; break; end
            if (!v_getn[i] || !v_putn[i]) idle = 0;
            else if (idle == TMO - 1) begin code = 3; runs = i + 1; break; end
            else idle++;
        end
    endfunction

    task automatic do_op(input logic [23:0] dcw, input logic [TAGW-1:0] tag,
                         input int n, input int hold);
        int code, src, dst, runs;
        int first_run, run_n, stat_at;
        bit good, rail_bad, busy_bad, hold_bad;
        logic [1:0]      c_code;
        logic [CNTW-1:0] c_src, c_dst;
        logic [TAGW-1:0] c_tag;
        good = ($countones(dcw[6:2]) == 1);
        if (good) model(n, code, src, dst, runs);
        else begin code = 2; src = 0; dst = 0; runs = 0; end
        @(negedge clk);
        check("op_ready_idle", op_ready, 1);
        op_valid = 1'b1; op_dc = dcw; op_tag = tag;
        first_run = -1; run_n = 0; stat_at = -1; rail_bad = 0; busy_bad = 0;
        for (int cyc = 1; cyc <= 200; cyc++) begin
            @(negedge clk);
            op_valid = 1'($urandom); op_dc = 24'($urandom); op_tag = TAGW'($urandom);
            if (m_reset === m_enable) rail_bad = 1;
            if (busy !== 1'b1 || op_ready !== 1'b0) busy_bad = 1;
            if (st_valid === 1'b1) begin stat_at = cyc; break; end
            m_src_getn = 1'($urandom); m_dst_putn = 1'($urandom);
            m_endn = 1'($urandom); abort = 1'($urandom);
            if (m_enable === 1'b1) begin
                if (first_run < 0) first_run = cyc;
                if (run_n < n) begin
                    m_src_getn = v_getn[run_n]; m_dst_putn = v_putn[run_n];
                    m_endn = v_endn[run_n]; abort = v_abort[run_n];
                end
                run_n++;
            end
        end
        if (stat_at < 0) begin
            check("stat_seen", 0, 1);
            op_valid = 1'b0;
            return;
        end
        check("dc_latched", dc, dcw);
        check("st_tag", st_tag, tag);
        check("st_code", st_code, code);
        check("st_src_cnt", st_src_cnt, src);
        check("st_dst_cnt", st_dst_cnt, dst);
        check("rails_complement", rail_bad, 0);
        check("busy_in_op", busy_bad, 0);
        if (good) begin
            check("rst_len", first_run, RST_CYC + 1);
            check("run_len", run_n, runs);
            check("stat_latency", stat_at, first_run + runs + ((code == 0) ? 0 : RST_CYC));
        end else begin
            check("badop_no_enable", first_run, -1);
            check("badop_latency", stat_at, 1);
        end
        c_code = st_code; c_src = st_src_cnt; c_dst = st_dst_cnt; c_tag = st_tag;
        hold_bad = 0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            op_valid = 1'b1; op_dc = 24'($urandom); op_tag = TAGW'($urandom);
            if (st_valid !== 1'b1 || op_ready !== 1'b0 || st_code !== c_code ||
                st_tag !== c_tag || st_src_cnt !== c_src || st_dst_cnt !== c_dst ||
                dc !== dcw) hold_bad = 1;
        end
        if (hold > 0) check("st_hold", hold_bad, 0);
        st_ready = 1'b1; op_valid = 1'b0;
        @(negedge clk);
        st_ready = 1'b0;
        check("st_valid_drop", st_valid, 0);
        check("op_ready_after_hs", op_ready, 1);
        check("busy_idle", busy, 0);
    endtask

    task automatic rand_op();
        int n, mode;
        logic [23:0] w;
        n = $urandom_range(1, 40);
        mode = $urandom_range(0, 2);
        clr_vec(n);
        for (int i = 0; i < n - 1; i++) begin
            if (mode == 0) begin
                v_getn[i] = ($urandom_range(0, 9) < 3);
                v_putn[i] = ($urandom_range(0, 9) < 3);
            end else begin
                v_getn[i] = ($urandom_range(0, 19) != 0);
                v_putn[i] = ($urandom_range(0, 19) != 0);
            end
            v_abort[i] = ($urandom_range(0, 39) == 0);
            v_endn[i]  = ($urandom_range(0, 39) != 0);
        end
        w = 24'($urandom);
        if ($urandom_range(0, 3) != 0) w[6:2] = 5'(1 << $urandom_range(0, 4));
        do_op(w, TAGW'($urandom), n, $urandom_range(0, 3));
    endtask

    initial begin
        int waited;
        bit seen;
        wb_rst_n = 1'b0; op_valid = 1'b0; op_dc = '0; op_tag = '0;
        m_endn = 1'b1; m_src_getn = 1'b1; m_dst_putn = 1'b1; abort = 1'b0; st_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_m_reset", m_reset, 1);
        check("rst_m_enable", m_enable, 0);
        check("rst_dc", dc, 0);
        check("rst_st_valid", st_valid, 0);
        check("rst_st_tag", st_tag, 0);
        check("rst_st_code", st_code, 0);
        check("rst_src", st_src_cnt, 0);
        check("rst_dst", st_dst_cnt, 0);
        check("rst_busy", busy, 0);
        check("rst_op_ready", op_ready, 0);
        wb_rst_n = 1'b1;
        @(negedge clk);
        check("op_ready_release", op_ready, 1);

        // copy: 5 pops/pushes then end
        clr_vec(6);
        for (int i = 0; i < 5; i++) begin v_getn[i] = 1'b0; v_putn[i] = 1'b0; end
        do_op(24'h000004, 4'd3, 6, 0);
        // encode+decode both set
        clr_vec(1);
        do_op(24'h000060, 4'd5, 1, 0);
        // 3 pops then silence -> timeout
        clr_vec(44);
        for (int i = 0; i < 3; i++) v_getn[i] = 1'b0;
        do_op(24'h000008, 4'd7, 44, 0);
        // end and abort in the same cycle -> end wins
        clr_vec(3);
        v_getn[0] = 1'b0; v_putn[1] = 1'b0; v_abort[2] = 1'b1;
        do_op(24'h000010, 4'd1, 3, 0);
        // abort alone
        clr_vec(10);
        v_getn[0] = 1'b0; v_abort[2] = 1'b1;
        do_op(24'h000020, 4'd2, 10, 0);
        // status backpressure
        clr_vec(4);
        v_putn[0] = 1'b0; v_getn[1] = 1'b0;
        do_op(24'h000040, 4'd12, 4, 20);
        // counter saturation
        clr_vec(21);
        for (int i = 0; i < 20; i++) v_putn[i] = 1'b0;
        do_op(24'h000004, 4'd9, 21, 0);

        for (int k = 0; k < 30; k++) rand_op();

        // reset mid-RUN: silent abort, no status
        m_endn = 1'b1; m_src_getn = 1'b1; m_dst_putn = 1'b1; abort = 1'b0;
        @(negedge clk);
        op_valid = 1'b1; op_dc = 24'h000010; op_tag = 4'd6;
        @(negedge clk);
        op_valid = 1'b0;
        waited = 0;
        while (m_enable !== 1'b1 && waited < 10) begin @(negedge clk); waited++; end
        check("midrst_in_run", m_enable, 1);
        m_src_getn = 1'b0;
        repeat (2) @(negedge clk);
        wb_rst_n = 1'b0; m_src_getn = 1'b1;
        @(negedge clk);
        check("midrst_m_enable", m_enable, 0);
        check("midrst_m_reset", m_reset, 1);
        check("midrst_st_valid", st_valid, 0);
        check("midrst_src", st_src_cnt, 0);
        check("midrst_busy", busy, 0);
        wb_rst_n = 1'b1;
        @(negedge clk);
        check("midrst_op_ready", op_ready, 1);
        seen = 0;
        repeat (6) begin @(negedge clk); if (st_valid !== 1'b0) seen = 1; end
        check("midrst_no_status", seen, 0);

        clr_vec(3);
        v_getn[0] = 1'b0;
        do_op(24'h000008, 4'd14, 3, 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
